// File: rtl/streamtodram_if.sv
`default_nettype none
// ============================================================================
// Module      : streamtodram_if
// Description : Sample input, DDR write master and CSR slave signal bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface streamtodram_if;
    logic signed [15:0] d_in;
    logic               vin;
    logic        [31:0] ddr_addr;
    logic               ddr_write;
    logic signed [15:0] ddr_writedata;
    logic               ddr_waitrequest;
    logic        [1:0]  addr;
    logic               read;
    logic               write;
    logic        [31:0] writedata;
    logic        [31:0] readdata;
    logic               done;

    modport master (
        output d_in, vin, ddr_waitrequest, addr, read, write, writedata,
        input  ddr_addr, ddr_write, ddr_writedata, readdata, done
    );

    modport slave (
        input  d_in, vin, ddr_waitrequest, addr, read, write, writedata,
        output ddr_addr, ddr_write, ddr_writedata, readdata, done
    );
endinterface
`default_nettype wire

// File: rtl/streamtodram.sv
`default_nettype none
// ============================================================================
// Module      : streamtodram
// Description : Buffers a signed sample stream and writes it to DDR over an
//               Avalon-MM master, configured and started through a CSR slave.
// Revision    : 1.0 - initial release
// ============================================================================
module streamtodram #(
    parameter int FIFO_DEPTH = 16
) (
    input  wire           clk,
    input  wire           rst,
    streamtodram_if.slave bus
);

    localparam int c_ptr_w = $clog2(FIFO_DEPTH);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_run   = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;

    logic [15:0]        r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;

    logic [31:0]        r_addr_init;
    logic [31:0]        r_stream_len;
    logic [31:0]        r_addr_step;
    logic [31:0]        r_ddr_addr;
    logic [31:0]        r_accepted;
    logic [31:0]        r_written;
    logic               r_overflow;
    logic [31:0]        r_readdata;

    logic               w_busy;
    logic               w_done;
    logic               w_run;
    logic               w_full;
    logic               w_empty;
    logic               w_start;
    logic               w_push;
    logic               w_pop;
    logic               w_ddr_write;
    logic [31:0]        w_rd_mux;

    assign w_busy  = (r_state == c_st_run) || (r_state == c_st_drain);
    assign w_done  = (r_state == c_st_done);
    assign w_run   = (r_state == c_st_run);
    // Occupancy never exceeds FIFO_DEPTH, so the top count bit alone means full.
    assign w_full  = r_count[c_ptr_w];
    assign w_empty = (r_count == '0);

    assign w_start     = bus.write && (bus.addr == 2'd3) && bus.writedata[0] && !w_busy;
    assign w_push      = w_run && bus.vin && !w_full && (r_accepted < r_stream_len);
    assign w_ddr_write = w_busy && !w_empty;
    assign w_pop       = w_ddr_write && !bus.ddr_waitrequest;

    assign bus.ddr_write     = w_ddr_write;
    assign bus.ddr_writedata = w_ddr_write ? r_mem[r_rd_ptr] : 16'sd0;
    assign bus.ddr_addr      = r_ddr_addr;
    assign bus.readdata      = r_readdata;
    assign bus.done          = w_done;

    always_comb begin
        w_rd_mux = 32'd0;
        case (bus.addr)
            2'd0:    w_rd_mux = r_addr_init;
            2'd1:    w_rd_mux = r_stream_len;
            2'd2:    w_rd_mux = r_addr_step;
            default: w_rd_mux = {29'd0, r_overflow, w_done, w_busy};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle, c_st_done: begin
                if (w_start) begin
                    w_state_next = (r_stream_len == 32'd0) ? c_st_done : c_st_run;
                end
            end
            c_st_run: begin
                if (r_accepted == r_stream_len) begin
                    w_state_next = c_st_drain;
                end
            end
            c_st_drain: begin
                if (r_written == r_stream_len) begin
                    w_state_next = c_st_done;
                end
            end
            default: w_state_next = c_st_idle;
        endcase
    end

    // Sample storage carries no reset; only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.d_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_addr_init  <= 32'd0;
            r_stream_len <= 32'd0;
            r_addr_step  <= 32'd1;
            r_ddr_addr   <= 32'd0;
            r_accepted   <= 32'd0;
            r_written    <= 32'd0;
            r_overflow   <= 1'b0;
            r_readdata   <= 32'd0;
        end else begin
            if (bus.read) begin
                r_readdata <= w_rd_mux;
            end

            if (bus.write && !w_busy) begin
                case (bus.addr)
                    2'd0:    r_addr_init  <= bus.writedata;
                    2'd1:    r_stream_len <= bus.writedata;
                    2'd2:    r_addr_step  <= bus.writedata;
                    default: ;
                endcase
            end

            if (w_start) begin
                r_ddr_addr <= r_addr_init;
                r_accepted <= 32'd0;
                r_written  <= 32'd0;
                r_overflow <= 1'b0;
            end

            if (w_push) begin
                r_wr_ptr   <= r_wr_ptr + 1'b1;
                r_accepted <= r_accepted + 32'd1;
            end

            if (w_run && bus.vin && w_full) begin
                r_overflow <= 1'b1;
            end

            if (w_pop) begin
                r_rd_ptr   <= r_rd_ptr + 1'b1;
                r_ddr_addr <= r_ddr_addr + r_addr_step;
                r_written  <= r_written + 32'd1;
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_streamtodram.sv
`default_nettype none
// ============================================================================
// Module      : tb_streamtodram
// Description : Directed self-checking bench for streamtodram.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_streamtodram;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_mis;

    logic [31:0] cap_addr[$];
    logic [15:0] cap_data[$];

    streamtodram_if bus();

    streamtodram #(.FIFO_DEPTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Completed transfers, in completion order.
    always @(posedge clk) begin
        if (!rst && bus.ddr_write && !bus.ddr_waitrequest) begin
            cap_addr.push_back(bus.ddr_addr);
            cap_data.push_back(bus.ddr_writedata);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic csr_write(input logic [1:0] a, input logic [31:0] d);
        bus.addr      = a;
        bus.writedata = d;
        bus.write     = 1'b1;
        @(negedge clk);
        bus.write     = 1'b0;
    endtask

    task automatic csr_read(input logic [1:0] a, output logic [31:0] d);
        bus.addr = a;
        bus.read = 1'b1;
        @(negedge clk);
        bus.read = 1'b0;
        d        = bus.readdata;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (!bus.done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, bus.done}, 32'd1);
    endtask

    task automatic config_run(input logic [31:0] a0, input logic [31:0] step, input logic [31:0] len);
        csr_write(2'd0, a0);
        csr_write(2'd2, step);
        csr_write(2'd1, len);
    endtask

    initial begin
        logic [31:0] rd;
        int          base;

        n_cmp = 0;
        n_mis = 0;
        rst                 = 1'b1;
        bus.d_in            = 16'sd0;
        bus.vin             = 1'b0;
        bus.ddr_waitrequest = 1'b0;
        bus.addr            = 2'd0;
        bus.read            = 1'b0;
        bus.write           = 1'b0;
        bus.writedata       = 32'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_readdata", bus.readdata, 32'd0);
        check("rst_ddr_write", {31'd0, bus.ddr_write}, 32'd0);
        check("rst_ddr_addr", bus.ddr_addr, 32'd0);
        check("rst_ddr_wdata", {16'd0, bus.ddr_writedata}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        csr_read(2'd0, rd); check("rst_addr_init", rd, 32'd0);
        csr_read(2'd1, rd); check("rst_stream_len", rd, 32'd0);
        csr_read(2'd3, rd); check("rst_status", rd, 32'd0);
        csr_read(2'd2, rd); check("rst_addr_step", rd, 32'd1);
        @(negedge clk);
        check("readdata_hold", bus.readdata, 32'd1);

        // Basic 4-sample stream
        base = cap_addr.size();
        config_run(32'h100, 32'd2, 32'd4);
        csr_write(2'd3, 32'd1);
        for (int i = 0; i < 4; i++) begin
            bus.d_in = 16'(i + 1);
            bus.vin  = 1'b1;
            @(negedge clk);
        end
        bus.vin = 1'b0;
        wait_done("t1_done_timeout", 40);
        check("t1_nwrites", 32'(cap_addr.size() - base), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (base + i < cap_addr.size()) begin
                check("t1_addr", cap_addr[base + i], 32'h100 + 32'(2 * i));
                check("t1_data", {16'd0, cap_data[base + i]}, 32'(i + 1));
            end
        end
        csr_read(2'd3, rd); check("t1_status", rd, 32'h2);

        // First write stalled for 5 cycles
        base = cap_addr.size();
        config_run(32'h200, 32'd4, 32'd8);
        bus.ddr_waitrequest = 1'b1;
        csr_write(2'd3, 32'd1);
        for (int i = 0; i < 8; i++) begin
            if (i >= 1 && i <= 5) begin
                check("t2_hold_write", {31'd0, bus.ddr_write}, 32'd1);
                check("t2_hold_addr", bus.ddr_addr, 32'h200);
                check("t2_hold_data", {16'd0, bus.ddr_writedata}, 32'h10);
            end
            if (i == 6) bus.ddr_waitrequest = 1'b0;
            bus.d_in = 16'(16'h10 + i);
            bus.vin  = 1'b1;
            @(negedge clk);
        end
        bus.vin = 1'b0;
        wait_done("t2_done_timeout", 60);
        check("t2_nwrites", 32'(cap_addr.size() - base), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (base + i < cap_addr.size()) begin
                check("t2_addr", cap_addr[base + i], 32'h200 + 32'(4 * i));
                check("t2_data", {16'd0, cap_data[base + i]}, 32'(16'h10 + i));
            end
        end
        csr_read(2'd3, rd); check("t2_status", rd, 32'h2);

        // 40-cycle stall overflows the 16-deep buffer; cycle k drives sample k+1
        base = cap_addr.size();
        config_run(32'h0, 32'd1, 32'd32);
        csr_write(2'd3, 32'd1);
        for (int k = 0; k < 70; k++) begin
            bus.ddr_waitrequest = (k < 40);
            bus.d_in = 16'(k + 1);
            bus.vin  = 1'b1;
            @(negedge clk);
        end
        bus.vin = 1'b0;
        bus.ddr_waitrequest = 1'b0;
        wait_done("t3_done_timeout", 100);
        check("t3_nwrites", 32'(cap_addr.size() - base), 32'd32);
        for (int j = 0; j < 32; j++) begin
            if (base + j < cap_addr.size()) begin
                check("t3_addr", cap_addr[base + j], 32'(j));
                check("t3_data", {16'd0, cap_data[base + j]}, (j < 16) ? 32'(j + 1) : 32'(j + 26));
            end
        end
        csr_read(2'd3, rd); check("t3_status", rd, 32'h6);

        // Zero-length stream
        base = cap_addr.size();
        csr_write(2'd1, 32'd0);
        csr_write(2'd3, 32'd1);
        check("t4_done_next", {31'd0, bus.done}, 32'd1);
        check("t4_no_write", {31'd0, bus.ddr_write}, 32'd0);
        repeat (3) @(negedge clk);
        check("t4_nwrites", 32'(cap_addr.size() - base), 32'd0);
        csr_read(2'd3, rd); check("t4_status", rd, 32'h2);

        // Address wrap, ignored start/CSR write while busy
        base = cap_addr.size();
        config_run(32'hFFFF_FFFE, 32'd2, 32'd2);
        bus.ddr_waitrequest = 1'b1;
        csr_write(2'd3, 32'd1);
        bus.d_in = 16'hAAAA; bus.vin = 1'b1;
        @(negedge clk);
        bus.d_in = 16'h5555;
        @(negedge clk);
        bus.vin = 1'b0;
        csr_write(2'd0, 32'h1234);
        csr_write(2'd3, 32'd1);
        csr_read(2'd0, rd); check("t5_addr_init_kept", rd, 32'hFFFF_FFFE);
        csr_read(2'd3, rd); check("t5_status_busy", rd, 32'h1);
        bus.ddr_waitrequest = 1'b0;
        wait_done("t5_done_timeout", 40);
        check("t5_nwrites", 32'(cap_addr.size() - base), 32'd2);
        if (base + 1 < cap_addr.size()) begin
            check("t5_addr0", cap_addr[base], 32'hFFFF_FFFE);
            check("t5_data0", {16'd0, cap_data[base]}, 32'hAAAA);
            check("t5_addr1", cap_addr[base + 1], 32'h0);
            check("t5_data1", {16'd0, cap_data[base + 1]}, 32'h5555);
        end

        // Reset during a stalled write
        base = cap_addr.size();
        config_run(32'h300, 32'd1, 32'd8);
        csr_write(2'd3, 32'd1);
        for (int k = 0; k < 8; k++) begin
            bus.ddr_waitrequest = (k >= 4);
            bus.d_in = 16'(16'h40 + k);
            bus.vin  = 1'b1;
            @(negedge clk);
        end
        bus.vin = 1'b0;
        check("t6_inflight", {31'd0, bus.ddr_write}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_write", {31'd0, bus.ddr_write}, 32'd0);
        check("t6_rst_addr", bus.ddr_addr, 32'd0);
        check("t6_rst_done", {31'd0, bus.done}, 32'd0);
        rst = 1'b0;
        bus.ddr_waitrequest = 1'b0;
        csr_read(2'd3, rd); check("t6_status", rd, 32'd0);
        csr_read(2'd2, rd); check("t6_addr_step", rd, 32'd1);
        check("t6_nwrites", 32'(cap_addr.size() - base), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (base + i < cap_addr.size()) begin
                check("t6_addr", cap_addr[base + i], 32'h300 + 32'(i));
                check("t6_data", {16'd0, cap_data[base + i]}, 32'(16'h40 + i));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
